// File: rtl/activation_streamer_pkg.sv
// Shared accelerator definitions: streamer FSM encoding and skid FIFO sizing.
package activation_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } stream_state_e;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/activation_streamer_skid_fifo.sv
// Two-entry FIFO absorbing buffer read latency; push/pop same cycle allowed.
// Zero-latency head (registered storage); caller must not push when full or pop when empty.
module act_skid_fifo
  import activation_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  not_empty,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign not_empty = (count_q != '0);
  assign count     = count_q;

endmodule

// File: rtl/activation_streamer.sv
// Streams a burst of activations from a 1-cycle-latency buffer into a valid/ready consumer.
// First beat 2 edges after start; reads are credit-gated so at most 2 beats are ever in flight.
module activation_streamer
  import activation_streamer_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_ACTIVATIONS = 256,
  parameter int ADDR_WIDTH      = $clog2(NUM_ACTIVATIONS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);

  stream_state_e         state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH:0]   beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  inflight_q, inflight_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  fifo_vld;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [FIFO_CNT_W-1:0] fifo_cnt;
  logic                  pop;
  logic                  reads_left;
  logic [2:0]            occupancy;
  logic [2:0]            limit;

  assign pop        = fifo_vld & out_ready;
  assign reads_left = (rd_cnt_q != len_q);
  // A beat leaving this cycle frees a slot for the read issued now.
  assign occupancy  = 3'(fifo_cnt) + 3'(inflight_q);
  assign limit      = 3'd2 + 3'(pop);
  assign rd_en      = (state_q == ST_STREAM) && reads_left && (occupancy < limit);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rd_cnt_d   = rd_cnt_q;
    beat_cnt_d = beat_cnt_q;
    rd_addr_d  = rd_addr_q;
    inflight_d = rd_en;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d      = length;
          rd_cnt_d   = '0;
          beat_cnt_d = '0;
          rd_addr_d  = base_addr;
          state_d    = (length == '0) ? ST_DONE : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (rd_en) begin
          rd_cnt_d  = rd_cnt_q + CNT_ONE;
          rd_addr_d = rd_addr_q + 1'b1;
        end
        if (pop) begin
          beat_cnt_d = beat_cnt_q + CNT_ONE;
          if (out_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      rd_cnt_q   <= '0;
      beat_cnt_q <= '0;
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rd_cnt_q   <= rd_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      rd_addr_q  <= rd_addr_d;
      inflight_q <= inflight_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  act_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight_q),
    .push_data(rd_data),
    .pop      (pop),
    .head_data(fifo_head),
    .not_empty(fifo_vld),
    .count    (fifo_cnt)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_addr   = rd_addr_q;
  assign out_valid = fifo_vld;
  assign out_data  = fifo_head;
  assign out_last  = fifo_vld && (beat_cnt_q == (len_q - CNT_ONE));

endmodule

// File: doc/activation_streamer.md
ACTIVATION_STREAMER -- requirements
Module: activation_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, activation word width.
REQ-002 SHALL have parameter NUM_ACTIVATIONS, default 256, depth of the upstream activation buffer.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(NUM_ACTIVATIONS), buffer address width.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to stream a burst; ignored unless idle.
REQ-007 base_addr  input  ADDR_WIDTH  first buffer address of the burst, sampled with start.
REQ-008 length  input  ADDR_WIDTH+1  beat count 0..NUM_ACTIVATIONS, sampled with start.
REQ-009 busy  output  1  high from start acceptance until done.
REQ-010 done  output  1  one-cycle pulse at burst end.
REQ-011 rd_en  output  1  buffer read_enable.
REQ-012 rd_addr  output  ADDR_WIDTH  buffer read_addr.
REQ-013 rd_data  input  DATA_WIDTH  buffer activation_data, valid the cycle after the edge that sampled rd_en.
REQ-014 out_valid  output  1  out_data holds a beat.
REQ-015 out_ready  input  1  consumer (systolic row) accepts beat.
REQ-016 out_data  output  DATA_WIDTH  activation beat.
REQ-017 out_last  output  1  high with the final beat of the burst.

Function
REQ-018 FSM states SHALL be IDLE, STREAM, DONE; reset state IDLE.
REQ-019 IDLE->STREAM on start when length!=0; IDLE->DONE on start when length==0 (no reads, no beats).
REQ-020 start while not IDLE SHALL be ignored; parameters of the running burst unchanged.
REQ-021 STREAM->DONE on the edge where the beat with out_last transfers; DONE->IDLE unconditionally next edge; done=1 only in DONE.
REQ-022 busy SHALL be 1 in STREAM and DONE, 0 in IDLE.
REQ-023 Reads SHALL be issued in order base_addr, base_addr+1, ..., exactly length reads, address wrapping modulo NUM_ACTIVATIONS (NUM_ACTIVATIONS is a power of two).
REQ-024 rd_en SHALL be high only in STREAM, reads remaining, and fifo_count + inflight - pop < 2, where inflight = rd_en sampled at previous edge, pop = out_valid & out_ready.
REQ-025 Returned rd_data SHALL be written into a 2-entry FIFO on the edge following the read's data cycle; simultaneous push and pop allowed.
REQ-026 out_valid = FIFO non-empty; out_data = FIFO head; transfer when out_valid & out_ready.
REQ-027 out_valid, once high, SHALL stay high with out_data stable until transfer.
REQ-028 out_last SHALL mark the head beat whose index equals length-1.
REQ-029 Latency: first out_valid SHALL assert 2 edges after the start-accepting edge; with out_ready held 1, one beat per cycle sustained.
REQ-030 Beat and read counters SHALL be ADDR_WIDTH+1 bits so length=NUM_ACTIVATIONS is exact.

Reset
REQ-031 On rst_n low, any cycle including mid-burst: state IDLE, FIFO empty, counters 0, inflight 0; busy, done, rd_en, out_valid, out_last = 0; rd_addr, out_data = 0.
REQ-032 A read in flight at reset SHALL be discarded; first start after reset behaves as from power-up.

Structure
REQ-033 FSM state encoding and the FIFO depth constant (2) SHALL live in the shared accelerator package.
REQ-034 The 2-entry FIFO SHALL be a sub-module named act_skid_fifo; the rest is flat.

Verification
REQ-035 Buffer preloaded mem[i]=i; start base=0x10 length=4, out_ready=1 -> beats 0x10..0x13 on consecutive cycles, out_last on 0x13, done pulse next cycle, busy low after.
REQ-036 base=0xFE length=4 -> rd_addr FE,FF,00,01; beats FE,FF,00,01.
REQ-037 length=8, out_ready toggled 1,0,0,1 repeating -> all 8 beats in order, none lost/duplicated, out_data stable while stalled, never more than 2 reads outstanding.
REQ-038 length=0 -> done pulse one cycle after start, no rd_en, no out_valid; length=256 base=0 -> 256 beats, out_last on beat 255.
REQ-039 start pulsed again mid-burst -> ignored, original burst completes unchanged.
REQ-040 rst_n low after 3 beats of length=16 -> all outputs 0 immediately; new start base=0 length=2 -> beats 0x00,0x01 only.
